// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-slave memory interconnect.
// Holds FSM states, error codes and the timeout counter width helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESPOND,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_PERM     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decoder: window match, permission check and
// slave-relative offset for the CPU request.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int N_SLAVES   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h1000_0000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
        {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000},
    parameter logic [N_SLAVES-1:0] EXEC_MASK = 3'b001,
    parameter logic [N_SLAVES-1:0] RO_MASK   = 3'b001
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  instr,
    input  logic                  write,
    output logic                  hit,
    output logic [N_SLAVES-1:0]   sel,
    output logic [ADDR_WIDTH-1:0] offset,
    output logic [1:0]            err_code
);

    // Scan from the top index down so the lowest matching slave wins.
    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        offset   = '0;
        err_code = ERR_UNMAPPED;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
                offset = addr - SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
                if ((instr && !EXEC_MASK[i]) || (write && RO_MASK[i]))
                    err_code = ERR_PERM;
                else
                    err_code = ERR_NONE;
            end
        end
    end

endmodule

// File: rtl/mem_bus_interconnect.sv
// picorv32 native port to N memory-mapped slaves, with registered
// select, timeout and sticky error status.
module mem_bus_interconnect
    import mem_bus_pkg::*;
#(
    parameter int N_SLAVES   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h1000_0000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
        {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000},
    parameter logic [N_SLAVES-1:0] EXEC_MASK = 3'b001,
    parameter logic [N_SLAVES-1:0] RO_MASK   = 3'b001,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                           clk_in,
    input  logic                           reset_n_in,
    input  logic                           mem_valid_in,
    input  logic                           mem_instr_in,
    input  logic [ADDR_WIDTH-1:0]          mem_addr_in,
    input  logic [DATA_WIDTH-1:0]          mem_wdata_in,
    input  logic [DATA_WIDTH/8-1:0]        mem_wstrb_in,
    output logic                           mem_ready_out,
    output logic [DATA_WIDTH-1:0]          mem_rdata_out,
    output logic [N_SLAVES-1:0]            slv_sel_out,
    output logic                           slv_write_out,
    output logic [ADDR_WIDTH-1:0]          slv_addr_out,
    output logic [DATA_WIDTH-1:0]          slv_wdata_out,
    output logic [DATA_WIDTH/8-1:0]        slv_wstrb_out,
    input  logic [N_SLAVES-1:0]            slv_ready_in,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] slv_rdata_in,
    input  logic                           err_clr_in,
    output logic                           bus_err_out,
    output logic [ADDR_WIDTH-1:0]          err_addr_out,
    output logic [1:0]                     err_code_out
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] req_addr;

    logic                  dec_hit;
    logic [N_SLAVES-1:0]   dec_sel;
    logic [ADDR_WIDTH-1:0] dec_off;
    logic [1:0]            dec_err;

    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  err_fire;
    logic [1:0]            err_fire_code;
    logic [ADDR_WIDTH-1:0] err_fire_addr;

    mem_bus_decode #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK),
        .EXEC_MASK  (EXEC_MASK),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .addr     (mem_addr_in),
        .instr    (mem_instr_in),
        .write    (|mem_wstrb_in),
        .hit      (dec_hit),
        .sel      (dec_sel),
        .offset   (dec_off),
        .err_code (dec_err)
    );

    assign sel_ready = |(slv_ready_in & slv_sel_out);

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (slv_sel_out[i])
                rdata_mux = rdata_mux | slv_rdata_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Single source of truth for "this edge enters ERROR".
    always_comb begin
        err_fire      = 1'b0;
        err_fire_code = ERR_NONE;
        err_fire_addr = '0;
        if (state == S_IDLE && mem_valid_in
            && !(dec_hit && dec_err == ERR_NONE)) begin
            err_fire      = 1'b1;
            err_fire_code = dec_err;
            err_fire_addr = mem_addr_in;
        end else if (state == S_ACCESS && !sel_ready && cnt == TMAX) begin
            err_fire      = 1'b1;
            err_fire_code = ERR_TIMEOUT;
            err_fire_addr = req_addr;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= S_IDLE;
            cnt           <= '0;
            req_addr      <= '0;
            mem_ready_out <= 1'b0;
            mem_rdata_out <= '0;
            slv_sel_out   <= '0;
            slv_write_out <= 1'b0;
            slv_addr_out  <= '0;
            slv_wdata_out <= '0;
            slv_wstrb_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_ready_out <= 1'b0;
                    if (mem_valid_in) begin
                        if (err_fire) begin
                            state         <= S_ERROR;
                            mem_ready_out <= 1'b1;
                            mem_rdata_out <= ERR_DATA;
                        end else begin
                            state         <= S_ACCESS;
                            cnt           <= '0;
                            req_addr      <= mem_addr_in;
                            slv_sel_out   <= dec_sel;
                            slv_addr_out  <= dec_off;
                            slv_wdata_out <= mem_wdata_in;
                            slv_wstrb_out <= mem_wstrb_in;
                            slv_write_out <= |mem_wstrb_in;
                        end
                    end
                end
                S_ACCESS: begin
                    if (sel_ready) begin
                        state         <= S_RESPOND;
                        slv_sel_out   <= '0;
                        mem_ready_out <= 1'b1;
                        mem_rdata_out <= slv_write_out ? '0 : rdata_mux;
                    end else if (err_fire) begin
                        state         <= S_ERROR;
                        slv_sel_out   <= '0;
                        mem_ready_out <= 1'b1;
                        mem_rdata_out <= ERR_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESPOND, S_ERROR: begin
                    state         <= S_IDLE;
                    mem_ready_out <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A fresh error beats a simultaneous clear.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            bus_err_out  <= 1'b0;
            err_addr_out <= '0;
            err_code_out <= ERR_NONE;
        end else if (err_fire && (!bus_err_out || err_clr_in)) begin
            bus_err_out  <= 1'b1;
            err_addr_out <= err_fire_addr;
            err_code_out <= err_fire_code;
        end else if (err_clr_in) begin
            bus_err_out  <= 1'b0;
            err_addr_out <= '0;
            err_code_out <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Directed bench for mem_bus_interconnect with an expected-read-data
// scoreboard popped on every CPU ready pulse.
module tb_mem_bus_interconnect;

    logic        clk;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready_out;
    logic [31:0] mem_rdata_out;
    logic [2:0]  slv_sel_out;
    logic        slv_write_out;
    logic [31:0] slv_addr_out;
    logic [31:0] slv_wdata_out;
    logic [3:0]  slv_wstrb_out;
    logic [2:0]  slv_ready;
    logic [95:0] slv_rdata;
    logic        err_clr;
    logic        bus_err_out;
    logic [31:0] err_addr_out;
    logic [1:0]  err_code_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    mem_bus_interconnect dut (
        .clk_in        (clk),
        .reset_n_in    (reset_n),
        .mem_valid_in  (mem_valid),
        .mem_instr_in  (mem_instr),
        .mem_addr_in   (mem_addr),
        .mem_wdata_in  (mem_wdata),
        .mem_wstrb_in  (mem_wstrb),
        .mem_ready_out (mem_ready_out),
        .mem_rdata_out (mem_rdata_out),
        .slv_sel_out   (slv_sel_out),
        .slv_write_out (slv_write_out),
        .slv_addr_out  (slv_addr_out),
        .slv_wdata_out (slv_wdata_out),
        .slv_wstrb_out (slv_wstrb_out),
        .slv_ready_in  (slv_ready),
        .slv_rdata_in  (slv_rdata),
        .err_clr_in    (err_clr),
        .bus_err_out   (bus_err_out),
        .err_addr_out  (err_addr_out),
        .err_code_out  (err_code_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic ins,
                       input logic [3:0] ws, input logic [31:0] wd,
                       input logic [31:0] exp);
        tick();
        mem_valid = 1'b1;
        mem_instr = ins;
        mem_addr  = a;
        mem_wstrb = ws;
        mem_wdata = wd;
        exp_q.push_back(exp);
    endtask

    task automatic await_ready(input string tag, input int budget,
                               output int cyc);
        cyc = 0;
        while (!mem_ready_out && cyc < budget) begin
            tick();
            cyc++;
        end
        check({tag, "_ready"}, 64'(mem_ready_out), 64'd1);
        check({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
            check({tag, "_rdata"}, 64'(mem_rdata_out), 64'(exp_q.pop_front()));
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic clear_err();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        int cyc;
        int n;

        reset_n   = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        err_clr   = 1'b0;
        slv_ready = 3'b000;
        slv_rdata = {32'h5555_AAAA, 32'hCAFE_0001, 32'h1234_5678};

        #2;
        check("rst_ready", 64'(mem_ready_out), 64'd0);
        check("rst_rdata", 64'(mem_rdata_out), 64'd0);
        check("rst_sel", 64'(slv_sel_out), 64'd0);
        check("rst_err", 64'(bus_err_out), 64'd0);
        check("rst_code", 64'(err_code_out), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // 1: fetch from ROM, ready on first ACCESS cycle
        slv_ready = 3'b001;
        req(32'h0000_0010, 1'b1, 4'h0, 32'h0, 32'h1234_5678);
        tick();
        check("t1_sel", 64'(slv_sel_out), 64'h1);
        check("t1_addr", 64'(slv_addr_out), 64'h10);
        check("t1_write", 64'(slv_write_out), 64'd0);
        await_ready("t1", 10, cyc);
        check("t1_lat", 64'(cyc), 64'd1);
        tick();
        check("t1_pulse", 64'(mem_ready_out), 64'd0);
        check("t1_hold", 64'(mem_rdata_out), 64'h1234_5678);

        // 2: write to RAM, slave1 ready on 4th cycle, slave0 ready ignored
        req(32'h0000_1004, 1'b0, 4'hF, 32'hA5A5_A5A5, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t2_sel", 64'(slv_sel_out), 64'h2);
            check("t2_addr", 64'(slv_addr_out), 64'h4);
            check("t2_write", 64'(slv_write_out), 64'd1);
            check("t2_wdata", 64'(slv_wdata_out), 64'hA5A5_A5A5);
            check("t2_wstrb", 64'(slv_wstrb_out), 64'hF);
            check("t2_noready", 64'(mem_ready_out), 64'd0);
            if (k == 4) slv_ready = 3'b011;
        end
        await_ready("t2", 10, cyc);
        check("t2_lat", 64'(cyc), 64'd1);
        slv_ready = 3'b001;
        tick();
        check("t2_pulse", 64'(mem_ready_out), 64'd0);

        // 3: unmapped read
        req(32'h2000_0000, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF);
        await_ready("t3", 10, cyc);
        check("t3_sel", 64'(slv_sel_out), 64'd0);
        check("t3_err", 64'(bus_err_out), 64'd1);
        check("t3_code", 64'(err_code_out), 64'd1);
        check("t3_eaddr", 64'(err_addr_out), 64'h2000_0000);
        clear_err();
        check("t3_clr", 64'(bus_err_out), 64'd0);

        // 4: permission errors and sticky status
        req(32'h0000_0000, 1'b0, 4'hF, 32'h1, 32'hDEAD_BEEF);
        await_ready("t4a", 10, cyc);
        check("t4a_sel", 64'(slv_sel_out), 64'd0);
        check("t4a_code", 64'(err_code_out), 64'd2);
        check("t4a_eaddr", 64'(err_addr_out), 64'h0);
        check("t4a_err", 64'(bus_err_out), 64'd1);
        req(32'h1000_0000, 1'b1, 4'h0, 32'h0, 32'hDEAD_BEEF);
        await_ready("t4b", 10, cyc);
        check("t4b_code", 64'(err_code_out), 64'd2);
        check("t4b_sticky", 64'(err_addr_out), 64'h0);
        req(32'h1000_0000, 1'b1, 4'h0, 32'h0, 32'hDEAD_BEEF);
        err_clr = 1'b1;
        await_ready("t4c", 10, cyc);
        err_clr = 1'b0;
        check("t4c_setwins", 64'(err_addr_out), 64'h1000_0000);
        check("t4c_err", 64'(bus_err_out), 64'd1);
        clear_err();
        check("t4_clr", 64'(bus_err_out), 64'd0);
        check("t4_clr_code", 64'(err_code_out), 64'd0);

        // 5: hung slave2 times out, next access is fine
        slv_ready = 3'b000;
        req(32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF);
        tick();
        n = 0;
        while (slv_sel_out == 3'b100 && n < 400) begin
            n++;
            tick();
        end
        check("t5_held", 64'(n), 64'd255);
        await_ready("t5", 2, cyc);
        check("t5_lat", 64'(cyc), 64'd0);
        check("t5_code", 64'(err_code_out), 64'd3);
        check("t5_eaddr", 64'(err_addr_out), 64'h1000_0000);
        slv_ready = 3'b010;
        req(32'h0000_1008, 1'b0, 4'h0, 32'h0, 32'hCAFE_0001);
        tick();
        check("t5n_sel", 64'(slv_sel_out), 64'h2);
        check("t5n_addr", 64'(slv_addr_out), 64'h8);
        await_ready("t5n", 10, cyc);

        // 6: reset in the middle of ACCESS
        slv_ready = 3'b000;
        req(32'h0000_1010, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("t6_sel_pre", 64'(slv_sel_out), 64'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_sel", 64'(slv_sel_out), 64'd0);
        check("t6_ready", 64'(mem_ready_out), 64'd0);
        check("t6_rdata", 64'(mem_rdata_out), 64'd0);
        check("t6_err", 64'(bus_err_out), 64'd0);
        check("t6_eaddr", 64'(err_addr_out), 64'd0);
        check("t6_saddr", 64'(slv_addr_out), 64'd0);
        mem_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_noready", 64'(mem_ready_out), 64'd0);
        end
        reset_n = 1'b1;
        slv_ready = 3'b001;
        req(32'h0000_0020, 1'b1, 4'h0, 32'h0, 32'h1234_5678);
        tick();
        check("t6n_sel", 64'(slv_sel_out), 64'h1);
        check("t6n_addr", 64'(slv_addr_out), 64'h20);
        await_ready("t6n", 10, cyc);
        check("t6n_lat", 64'(cyc), 64'd1);

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_interconnect.md
Name: mem_bus_interconnect

Overview:
Parametrised interconnect between the picorv32 native memory port and N memory-mapped slaves (ROM, RAM, IO register, future peripherals). It replaces the ad-hoc enable decode and the shared, multiply-driven mem_rdata/mem_ready nets in the top level. Responsibilities:
- Decode the CPU address against per-slave base/mask windows.
- Register the select and request to the chosen slave and present the slave-relative offset address.
- Mux read data and ready back to the CPU.
- Convert unmapped, illegal or hung accesses into a terminated error response with sticky status.

Parameters:
N_SLAVES, 3, number of slave ports
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SLV_BASE, {32'h1000_0000, 32'h0000_1000, 32'h0000_0000}, flattened N_SLAVES*ADDR_WIDTH base addresses; slave i occupies slice i
SLV_MASK, {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000}, flattened compare masks; hit when (addr & mask) == base
EXEC_MASK, 3'b001, bit i set: instruction fetch permitted from slave i
RO_MASK, 3'b001, bit i set: writes to slave i are errors
TIMEOUT, 255, maximum cycles waiting for slave ready
ERR_DATA, 32'hDEAD_BEEF, read data returned on an error

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
mem_valid_in  input  1  CPU request valid
mem_instr_in  input  1  request is an instruction fetch
mem_addr_in  input  ADDR_WIDTH  CPU address
mem_wdata_in  input  DATA_WIDTH  CPU write data
mem_wstrb_in  input  DATA_WIDTH/8  byte write strobes; nonzero means write
mem_ready_out  output  1  transfer complete, one-cycle pulse
mem_rdata_out  output  DATA_WIDTH  read data to CPU
slv_sel_out  output  N_SLAVES  one-hot slave enable
slv_write_out  output  1  write request
slv_addr_out  output  ADDR_WIDTH  address minus selected base
slv_wdata_out  output  DATA_WIDTH  write data
slv_wstrb_out  output  DATA_WIDTH/8  byte strobes
slv_ready_in  input  N_SLAVES  per-slave ready
slv_rdata_in  input  N_SLAVES*DATA_WIDTH  per-slave read data, flattened
err_clr_in  input  1  clears sticky error status
bus_err_out  output  1  sticky error flag
err_addr_out  output  ADDR_WIDTH  address of first uncleared error
err_code_out  output  2  0 none, 1 unmapped, 2 permission, 3 timeout

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0, including mem_rdata_out, slv_sel_out and the error registers. An in-flight access is dropped; no ready is issued.
- FSM states: IDLE, ACCESS, RESPOND, ERROR.
- IDLE, mem_valid_in=1, decode hit: latch the request and go to ACCESS.
  - Overlapping windows: the lowest slave index wins.
  - Next cycle: slv_sel_out one-hot; slv_addr/wdata/wstrb/write are registered copies.
- IDLE, decode fails: go to ERROR and do not assert any select.
  - No hit: code 1.
  - Fetch from a slave without its EXEC_MASK bit: code 2.
  - Write to a slave with its RO_MASK bit set: code 2.
- ACCESS:
  - Select and request outputs are held stable.
  - The timeout counter starts at 0 and increments each cycle.
  - On slv_ready_in[sel] = 1: capture that slave's rdata, drop the select, go to RESPOND.
  - Ready from non-selected slaves is ignored.
  - If the counter reaches TIMEOUT with no ready: drop the select and go to ERROR with code 3.
- RESPOND: mem_ready_out = 1 for exactly one cycle, with mem_rdata_out = captured data (0 on writes). Then go to IDLE.
- ERROR: mem_ready_out = 1 for one cycle, mem_rdata_out = ERR_DATA. Then go to IDLE. The CPU is never stalled forever.
- Minimum latency: request to mem_ready_out is 3 cycles for a slave with ready in the first ACCESS cycle.
- mem_rdata_out holds its last value when mem_ready_out = 0.
- mem_valid_in is sampled only in IDLE. The CPU deasserts it after ready, so the IDLE cycle following RESPOND sees it low.
- Sticky status:
  - On entry to ERROR with bus_err_out = 0: set bus_err_out and latch err_addr_out and err_code_out.
  - Later errors do not overwrite the status until it is cleared.
  - If err_clr_in and a new error occur in the same cycle, the set wins and the new error is latched.
- Address arithmetic: slv_addr_out = addr - base, modulo 2^ADDR_WIDTH.

Decomposition:
- Package mem_bus_pkg holds:
  - the FSM state enum;
  - the err_code constants (ERR_NONE, ERR_UNMAPPED, ERR_PERM, ERR_TIMEOUT);
  - a width function for the timeout counter, clog2(TIMEOUT+1).
- Sub-module mem_bus_decode is purely combinational. It takes addr, instr and write, and returns hit, the one-hot index, offset and err_code.

Test Plan:
1. Fetch from 0x0000_0010, slave0 ready on its first ACCESS cycle with data 0x1234_5678 -> slv_sel_out = 3'b001 and slv_addr_out = 0x10; mem_ready_out pulses at cycle 3 with mem_rdata_out = 0x1234_5678.
2. Write to 0x0000_1004 with wstrb 4'b1111 and data 0xA5A5_A5A5, slave1 ready after 4 cycles -> slv_sel_out = 3'b010, slv_addr_out = 0x4, slv_write_out = 1, stable for all 4 cycles; one ready pulse.
3. Read of 0x2000_0000 (unmapped) -> no select; mem_rdata_out = 0xDEAD_BEEF with ready; bus_err_out = 1, err_code_out = 1, err_addr_out = 0x2000_0000.
4. Write to 0x0000_0000 (ROM is read-only) and fetch from 0x1000_0000 (IO is not executable) -> both give an error response with code 2; err_addr_out stays 0x0000_0000 until err_clr_in pulses.
5. Read of 0x1000_0000 with slave2 never ready -> select held for 255 cycles, then an ERR_DATA response and code 3; the next access completes normally.
6. Assert reset_n_in low mid-ACCESS -> all outputs 0 immediately, no ready pulse; after release, a normal access succeeds.
